vend_dispenser: RTL and testbench
=================================

# vend_dispenser

Dispenser/payout unit at the far end of the vending controller's `dispenser_go` / `dispenser_done_signal` handshake. Accepts a vend code and change amount, runs the slot motor, decrements and owns the 10-slot inventory, then pays change greedily as one-coin pulses before signalling done. It drives `inventory_signal` back to the controller and the price/inventory lookup.

## Interface
- `MOTOR_CYCLES`, 4: cycles `motor_en` is held per item (1–255).
- `COIN_GAP`, 2: idle cycles after each coin pulse (0–15).
- `INIT_COUNT`, 4'd9: per-slot count loaded at reset and restock.
- `clk`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dispenser_go`  in  1  start request, level from controller, accepted on its rising edge.
- `vend`  in  9  vend code, sampled at accept.
- `change`  in  10  change in cents, sampled at accept.
- `restock`  in  1  reload all slot counts to `INIT_COUNT`.
- `dispenser_done_signal`  out  1  one-cycle completion pulse.
- `dispenser_busy`  out  1  high from the cycle after accept through the done cycle.
- `inventory_signal`  out  40  slot n count at bits [4n+3:4n], n = 0..9.
- `motor_en`  out  1  slot motor drive.
- `motor_slot`  out  4  slot being driven; valid while `motor_en`.
- `coin_out`  out  5  one-hot coin eject pulse: [4]=100, [3]=25, [2]=10, [1]=5, [0]=1 cent.
- `sold_out_err`  out  1  sticky until next accept; set when the requested slot is empty or invalid.

## Operation
- States: IDLE, VEND, COIN, GAP, DONE.
- IDLE: `go_q` registers `dispenser_go` every cycle. Accept occurs when `dispenser_go & !go_q`. On accept:
  - latch `vend[3:0]` into the slot register and `change` into the 10-bit `remaining`;
  - clear `sold_out_err`.
- Item decode at accept:
  - `vend == 0`: no item, go to COIN.
  - `vend[3:0] > 9`: no item, set `sold_out_err`, go to COIN.
  - Slot count is 0: no motor, set `sold_out_err`, go to COIN.
  - Otherwise go to VEND.
- VEND: `motor_en`=1 and `motor_slot`=slot for exactly `MOTOR_CYCLES` cycles. On the last cycle the slot count decrements by 1 (new value visible the next cycle), then go to COIN.
- COIN:
  - If `remaining == 0`, go to DONE with no pulse.
  - Otherwise emit one `coin_out` bit for one cycle: the largest denomination ≤ `remaining`. Subtract it from `remaining` (10-bit unsigned; never underflows).
  - Then go to GAP, or stay in COIN if `COIN_GAP == 0`.
- GAP: wait `COIN_GAP` cycles, then return to COIN.
- DONE: `dispenser_done_signal`=1 for one cycle, then IDLE. `dispenser_busy` falls the cycle after DONE.
- `dispenser_go` seen while not in IDLE is ignored. A new accept requires `dispenser_go` low for at least one cycle in IDLE.
- `restock`:
  - acted on only in IDLE with no accept that cycle, and reloads all ten counts;
  - ignored while busy or on the accept cycle.
- Counts never go below 0 and never exceed `INIT_COUNT` by restock.

## Timing
- Reset values:
  - all outputs 0, except `inventory_signal` = ten copies of `INIT_COUNT`;
  - state IDLE; `go_q`, `remaining` and slot register cleared.
- Reset mid-operation aborts immediately. Unpaid change is lost, and a decrement not yet applied is lost.
- Accept at cycle A. `dispenser_busy`=1 from A+1.
- With an item: `motor_en` spans A+1..A+`MOTOR_CYCLES`; the first COIN cycle is A+`MOTOR_CYCLES`+1.
- Without an item: the first COIN cycle is A+1.
- Each coin costs 1+`COIN_GAP` cycles. The final COIN cycle (remaining 0) costs 1 cycle, then DONE.
- Minimum accept-to-done latency is 2 cycles (no item, change 0). The controller waits for done, so any latency ≥ 2 is legal.
- Worst-case payout is 1023 cents = 10×100 + 2×10 + 3×1 = 15 coins.

## Test plan
- Reset with defaults → `inventory_signal` = 40'h9999999999, all other outputs 0.
- Item plus change, defaults (`MOTOR_CYCLES`=4, `COIN_GAP`=2):
  - stimulus: `vend`=9'h105, `change`=40, go rises at A;
  - required: `motor_en` A+1..A+4 with `motor_slot`=5; slot 5 count reads 8 at A+5;
  - coin pulses 25@A+5, 10@A+8, 5@A+11; done@A+15; busy low at A+16.
- Return only: `vend`=0, `change`=1023 → no motor, 15 coin pulses in greedy order (100×10, 10×2, 1×3), then done.
- Sold-out/invalid:
  - drain slot 3 to 0, then request `vend`=9'h103, `change`=0 → `sold_out_err`=1, no motor, done at A+2, count stays 0;
  - `vend`=9'h10C → same response.
- Handshake abuse:
  - hold go high across done → no second accept until go drops for one cycle;
  - restock while busy → ignored; restock in IDLE → all counts restored to 9.
- Reset mid-payout (during GAP after the first coin) → next cycle all outputs 0, inventory reset, no done pulse.

Source files
------------

// File: rtl/vend_dispenser_if.sv
// -----------------------------------------------------------------------------
// vend_dispenser_if
// Handshake and status bundle between the vending controller (master) and the
// dispenser/payout unit (slave).
//   dispenser_go           controller -> dispenser  start request (level)
//   vend[8:0]              controller -> dispenser  vend code
//   change[9:0]            controller -> dispenser  change to pay, in cents
//   restock                controller -> dispenser  reload all slot counts
//   dispenser_done_signal  dispenser -> controller  one-cycle completion pulse
//   dispenser_busy         dispenser -> controller  transaction in progress
//   inventory_signal[39:0] dispenser -> controller  ten 4-bit slot counts
//   motor_en, motor_slot   dispenser -> controller  slot motor drive
//   coin_out[4:0]          dispenser -> controller  one-hot coin eject pulse
//   sold_out_err           dispenser -> controller  requested slot empty/invalid
// -----------------------------------------------------------------------------
interface vend_dispenser_if;
   logic        dispenser_go;
   logic [8:0]  vend;
   logic [9:0]  change;
   logic        restock;
   logic        dispenser_done_signal;
   logic        dispenser_busy;
   logic [39:0] inventory_signal;
   logic        motor_en;
   logic [3:0]  motor_slot;
   logic [4:0]  coin_out;
   logic        sold_out_err;

   modport master (
      output dispenser_go, vend, change, restock,
      input  dispenser_done_signal, dispenser_busy, inventory_signal,
             motor_en, motor_slot, coin_out, sold_out_err
   );

   modport slave (
      input  dispenser_go, vend, change, restock,
      output dispenser_done_signal, dispenser_busy, inventory_signal,
             motor_en, motor_slot, coin_out, sold_out_err
   );
endinterface

// File: rtl/vend_dispenser.sv
// -----------------------------------------------------------------------------
// vend_dispenser
// Dispenser/payout unit. Accepts a vend code and change amount on the rising
// edge of dispenser_go, runs the slot motor for MOTOR_CYCLES cycles, decrements
// the owned 10-slot inventory, pays change greedily as one-coin pulses spaced
// by COIN_GAP idle cycles, then pulses dispenser_done_signal.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    vend_dispenser_if.slave (handshake, inventory, motor, coin outputs)
// -----------------------------------------------------------------------------
module vend_dispenser #(
   parameter int unsigned MOTOR_CYCLES = 4,
   parameter int unsigned COIN_GAP     = 2,
   parameter logic [3:0]  INIT_COUNT   = 4'd9
) (
   input  logic              clk,
   input  logic              reset,
   vend_dispenser_if.slave   bus
);

   typedef enum logic [2:0] {S_IDLE, S_VEND, S_COIN, S_GAP, S_DONE} state_t;

   localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYCLES - 1);
   // GAP is never entered when COIN_GAP is 0, so its terminal value is moot then.
   localparam logic [3:0] GAP_LAST   = (COIN_GAP == 0) ? 4'd0 : 4'(COIN_GAP - 1);

   state_t      state, state_nxt;
   logic        go_q;
   logic [3:0]  slot_q;
   logic [9:0]  remaining;
   logic [7:0]  motor_cnt;
   logic [3:0]  gap_cnt;
   logic [39:0] inv;
   logic        sold_out_q;

   logic        accept;
   logic        slot_valid;
   logic [3:0]  req_cnt;
   logic        item_ok;
   logic        item_bad;
   logic        motor_last;
   logic        gap_last;
   logic [4:0]  coin_sel;

   logic        done_c, busy_c, motor_en_c;
   logic [3:0]  motor_slot_c;
   logic [4:0]  coin_c;

   // Largest denomination not exceeding the amount; zero when nothing is owed.
   function automatic logic [4:0] pick_coin(input logic [9:0] amt);
      if (amt >= 10'd100)     return 5'b10000;
      else if (amt >= 10'd25) return 5'b01000;
      else if (amt >= 10'd10) return 5'b00100;
      else if (amt >= 10'd5)  return 5'b00010;
      else if (amt != 10'd0)  return 5'b00001;
      else                    return 5'b00000;
   endfunction

   function automatic logic [9:0] coin_value(input logic [4:0] coin);
      case (coin)
         5'b10000: return 10'd100;
         5'b01000: return 10'd25;
         5'b00100: return 10'd10;
         5'b00010: return 10'd5;
         5'b00001: return 10'd1;
         default:  return 10'd0;
      endcase
   endfunction

   assign accept     = (state == S_IDLE) && bus.dispenser_go && !go_q;
   assign slot_valid = (bus.vend[3:0] <= 4'd9);

   // Count of the requested slot; out-of-range slots read as zero.
   always_comb begin
      req_cnt = 4'd0;
      for (int n = 0; n < 10; n++) begin
         if (bus.vend[3:0] == 4'(n)) req_cnt = inv[4*n +: 4];
      end
   end

   assign item_ok    = (bus.vend != 9'd0) && slot_valid && (req_cnt != 4'd0);
   assign item_bad   = (bus.vend != 9'd0) && (!slot_valid || (req_cnt == 4'd0));
   assign motor_last = (motor_cnt == MOTOR_LAST);
   assign gap_last   = (gap_cnt == GAP_LAST);
   assign coin_sel   = pick_coin(remaining);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      done_c       = 1'b0;
      busy_c       = 1'b1;
      motor_en_c   = 1'b0;
      motor_slot_c = 4'd0;
      coin_c       = 5'd0;
      case (state)
         S_IDLE: begin
            busy_c = 1'b0;
            if (accept) state_nxt = item_ok ? S_VEND : S_COIN;
         end
         S_VEND: begin
            motor_en_c   = 1'b1;
            motor_slot_c = slot_q;
            if (motor_last) state_nxt = S_COIN;
         end
         S_COIN: begin
            coin_c = coin_sel;
            if (remaining == 10'd0)  state_nxt = S_DONE;
            else if (COIN_GAP != 0)  state_nxt = S_GAP;
         end
         S_GAP: begin
            if (gap_last) state_nxt = S_COIN;
         end
         S_DONE: begin
            done_c    = 1'b1;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         go_q       <= 1'b0;
         slot_q     <= 4'd0;
         remaining  <= 10'd0;
         motor_cnt  <= 8'd0;
         gap_cnt    <= 4'd0;
         sold_out_q <= 1'b0;
         inv        <= {10{INIT_COUNT}};
      end else begin
         go_q <= bus.dispenser_go;
         case (state)
            S_IDLE: begin
               if (accept) begin
                  slot_q     <= bus.vend[3:0];
                  remaining  <= bus.change;
                  sold_out_q <= item_bad;
                  motor_cnt  <= 8'd0;
               end else if (bus.restock) begin
                  inv <= {10{INIT_COUNT}};
               end
            end
            S_VEND: begin
               motor_cnt <= motor_cnt + 8'd1;
               // Decrement lands on the last motor cycle; guarded against wrap.
               if (motor_last) begin
                  for (int n = 0; n < 10; n++) begin
                     if ((slot_q == 4'(n)) && (inv[4*n +: 4] != 4'd0))
                        inv[4*n +: 4] <= inv[4*n +: 4] - 4'd1;
                  end
               end
            end
            S_COIN: begin
               remaining <= remaining - coin_value(coin_sel);
               gap_cnt   <= 4'd0;
            end
            S_GAP: begin
               gap_cnt <= gap_cnt + 4'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.dispenser_done_signal = done_c;
   assign bus.dispenser_busy        = busy_c;
   assign bus.motor_en              = motor_en_c;
   assign bus.motor_slot            = motor_slot_c;
   assign bus.coin_out              = coin_c;
   assign bus.sold_out_err          = sold_out_q;
   assign bus.inventory_signal      = inv;

endmodule

// File: tb/tb_vend_dispenser.sv
`timescale 1ns/1ps
module tb_vend_dispenser;
   localparam int MC  = 4;
   localparam int GAP = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   vend_dispenser_if bus ();

   vend_dispenser #(.MOTOR_CYCLES(MC), .COIN_GAP(GAP), .INIT_COUNT(4'd9)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      int          a;
      bit          item;
      int          slot;
      bit          sold;
      int          done_at;
      logic [39:0] inv;
   } txn_t;

   typedef struct {
      int at;
      int val;
   } coin_t;

   int    tests = 0;
   int    fails = 0;
   int    cyc = 0;
   int    done_cnt = 0;
   int    model_cnt [10];
   txn_t  txq [$];
   coin_t cq [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [39:0] pack_inv();
      logic [39:0] r;
      for (int n = 0; n < 10; n++) r[4*n +: 4] = 4'(model_cnt[n]);
      return r;
   endfunction

   // Reference model: item decision, greedy payout schedule and final inventory.
   task automatic issue(input logic [8:0] v, input logic [9:0] c);
      txn_t t;
      int   rem, at;
      int   denom [5] = '{100, 25, 10, 5, 1};
      t.a    = cyc;
      t.slot = int'(v[3:0]);
      t.item = 1'b0;
      t.sold = 1'b0;
      if (v != 9'd0) begin
         if (t.slot > 9)                  t.sold = 1'b1;
         else if (model_cnt[t.slot] == 0) t.sold = 1'b1;
         else begin
            t.item = 1'b1;
            model_cnt[t.slot] = model_cnt[t.slot] - 1;
         end
      end
      at  = t.a + 1 + (t.item ? MC : 0);
      rem = int'(c);
      for (int i = 0; i < 5; i++) begin
         while (rem >= denom[i]) begin
            cq.push_back('{at, denom[i]});
            rem = rem - denom[i];
            at  = at + 1 + GAP;
         end
      end
      t.done_at = at + 1;
      t.inv     = pack_inv();
      txq.push_back(t);
   endtask

   txn_t  mon_t;
   coin_t mon_c;
   int    mon_v;

   always @(negedge clk) begin
      if (!reset) begin
         check("busy", bus.dispenser_busy, (txq.size() != 0) && (cyc > txq[0].a));
         if (bus.motor_en) begin
            if (txq.size() == 0) check("motor_unexpected", 1, 0);
            else begin
               check("motor_window", txq[0].item && (cyc > txq[0].a) && (cyc <= txq[0].a + MC), 1);
               check("motor_slot", bus.motor_slot, txq[0].slot);
            end
         end
         if ((txq.size() != 0) && txq[0].item && (cyc == txq[0].a + MC + 1))
            check("inv_after_motor", bus.inventory_signal, txq[0].inv);
         if (bus.coin_out != 5'd0) begin
            case (bus.coin_out)
               5'b10000: mon_v = 100;
               5'b01000: mon_v = 25;
               5'b00100: mon_v = 10;
               5'b00010: mon_v = 5;
               5'b00001: mon_v = 1;
               default:  mon_v = -1;
            endcase
            if (cq.size() == 0) check("coin_unexpected", mon_v, 0);
            else begin
               mon_c = cq.pop_front();
               check("coin_value", mon_v, mon_c.val);
               check("coin_cycle", cyc, mon_c.at);
            end
         end
         if (bus.dispenser_done_signal) begin
            if (txq.size() == 0) check("done_unexpected", 1, 0);
            else begin
               mon_t = txq.pop_front();
               check("done_cycle", cyc, mon_t.done_at);
               check("sold_out_err", bus.sold_out_err, mon_t.sold);
               check("inv_at_done", bus.inventory_signal, mon_t.inv);
               check("coins_left", cq.size(), 0);
            end
            done_cnt++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int prev, input int budget);
      int n = 0;
      while ((done_cnt == prev) && (n < budget)) begin
         tick();
         n++;
      end
      check("done_timeout", done_cnt != prev, 1);
   endtask

   task automatic do_vend(input logic [8:0] v, input logic [9:0] c, input bit hold);
      int prev = done_cnt;
      bus.dispenser_go = 1'b0;
      tick();
      bus.vend         = v;
      bus.change       = c;
      bus.dispenser_go = 1'b1;
      issue(v, c);
      tick();
      if (!hold) bus.dispenser_go = 1'b0;
      // Inputs are only sampled at accept; scramble them afterwards.
      bus.vend   = 9'($urandom);
      bus.change = 10'($urandom);
      wait_done(prev, 200);
      tick();
   endtask

   task automatic do_restock();
      bus.dispenser_go = 1'b0;
      tick();
      bus.restock = 1'b1;
      tick();
      bus.restock = 1'b0;
      for (int n = 0; n < 10; n++) model_cnt[n] = 9;
      check("restock_inv", bus.inventory_signal, pack_inv());
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_done"},  bus.dispenser_done_signal, 0);
      check({tag, "_busy"},  bus.dispenser_busy, 0);
      check({tag, "_motor"}, bus.motor_en, 0);
      check({tag, "_mslot"}, bus.motor_slot, 0);
      check({tag, "_coin"},  bus.coin_out, 0);
      check({tag, "_sold"},  bus.sold_out_err, 0);
      check({tag, "_inv"},   bus.inventory_signal, 40'h9999999999);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int          prev, a;
      logic [8:0]  v;
      logic [9:0]  c;
      reset            = 1'b1;
      bus.dispenser_go = 1'b0;
      bus.vend         = 9'd0;
      bus.change       = 10'd0;
      bus.restock      = 1'b0;
      for (int n = 0; n < 10; n++) model_cnt[n] = 9;
      tick();
      tick();
      check_reset_outputs("reset");
      reset = 1'b0;
      tick();

      // Item plus change: motor on slot 5, coins 25/10/5.
      do_vend(9'h105, 10'd40, 1'b0);
      // Return only, worst-case payout.
      do_vend(9'h000, 10'd1023, 1'b0);

      // Drain slot 3, then request it empty and request an invalid slot.
      while (model_cnt[3] > 0) do_vend(9'h103, 10'($urandom_range(0, 12)), 1'b0);
      do_vend(9'h103, 10'd0, 1'b0);
      check("slot3_empty", bus.inventory_signal[15:12], 0);
      do_vend(9'h10C, 10'd0, 1'b0);

      // Go held high across done: no second accept.
      prev = done_cnt;
      do_vend(9'h101, 10'd7, 1'b1);
      repeat (6) tick();
      check("hold_go_no_reaccept", done_cnt, prev + 1);
      check("hold_go_idle", bus.dispenser_busy, 0);
      bus.dispenser_go = 1'b0;

      // Restock on the accept cycle and while busy is ignored.
      prev = done_cnt;
      tick();
      bus.vend         = 9'h102;
      bus.change       = 10'd13;
      bus.dispenser_go = 1'b1;
      bus.restock      = 1'b1;
      issue(9'h102, 10'd13);
      tick();
      bus.dispenser_go = 1'b0;
      tick();
      tick();
      bus.restock = 1'b0;
      wait_done(prev, 200);
      tick();
      do_restock();

      // Reset during the gap after the first coin.
      prev = done_cnt;
      tick();
      bus.vend         = 9'h000;
      bus.change       = 10'd300;
      bus.dispenser_go = 1'b1;
      issue(9'h000, 10'd300);
      a = cyc;
      tick();
      bus.dispenser_go = 1'b0;
      while (cyc < a + 2) tick();
      reset = 1'b1;
      tick();
      txq.delete();
      cq.delete();
      for (int n = 0; n < 10; n++) model_cnt[n] = 9;
      check_reset_outputs("midreset");
      reset = 1'b0;
      repeat (20) tick();
      check("no_done_after_reset", done_cnt, prev);

      // Randomized transactions.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 7) == 0) do_restock();
         case ($urandom_range(0, 3))
            0:       v = 9'h000;
            1:       v = 9'h100 | 9'($urandom_range(0, 9));
            2:       v = 9'h100 | 9'($urandom_range(10, 15));
            default: v = 9'($urandom);
         endcase
         if ($urandom_range(0, 1) == 0) c = 10'($urandom_range(0, 60));
         else                           c = 10'($urandom_range(0, 1023));
         do_vend(v, c, 1'b0);
      end

      repeat (3) tick();
      check("final_queue_empty", txq.size() + cq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
